// File: rtl/fetch_if.sv
// Bundle between the PC sequencer and the rest of the fetch/hazard logic.
// Every signal is level-sampled on the rising clock edge; there is no handshake.
interface fetch_if #(
   parameter int PC_W = 8
);
   logic            stall;
   logic            branch_taken;
   logic [PC_W-1:0] branch_target;
   logic            jump;
   logic [PC_W-1:0] jump_target;
   logic            halt_req;
   logic [PC_W-1:0] pc_out;
   logic            if_flush;
   logic            fetch_valid;
   logic            halted;
   logic [15:0]     stall_cycles;

   // master: the sequencer itself; slave: hazard unit, EX/ID redirects and IF.
   modport master (
      input  stall, branch_taken, branch_target, jump, jump_target, halt_req,
      output pc_out, if_flush, fetch_valid, halted, stall_cycles
   );

   modport slave (
      output stall, branch_taken, branch_target, jump, jump_target, halt_req,
      input  pc_out, if_flush, fetch_valid, halted, stall_cycles
   );
endinterface

// File: rtl/fetch_ctrl.sv
// Program-counter sequencer for the IF stage: increment, stall hold, redirect
// with wrong-path flush, sticky halt, and a saturating stall-cycle counter.
module fetch_ctrl #(
   parameter int PC_W         = 8,
   parameter int RESET_PC     = 0,
   parameter int PC_STEP      = 1,
   parameter int FLUSH_CYCLES = 1
) (
   input  logic       clk,
   input  logic       rst,
   fetch_if.master    bus,
   output logic [1:0] state_dbg
);
   typedef enum logic [1:0] {S_RUN, S_STALL, S_FLUSH, S_HALT} state_t;

   localparam logic [PC_W-1:0] RST_PC     = PC_W'(RESET_PC);
   localparam logic [PC_W-1:0] STEP       = PC_W'(PC_STEP);
   localparam logic [1:0]      FLUSH_LOAD = 2'(FLUSH_CYCLES);

   state_t          state_q, state_d;
   logic [PC_W-1:0] pc_q, pc_d;
   logic [1:0]      cnt_q, cnt_d;
   logic            warm_q;
   logic            stall_hit;
   logic [15:0]     stall_cnt_q, stall_cnt_d;
   logic            if_flush_q, if_flush_d;
   logic            fetch_valid_q, fetch_valid_d;
   logic            halted_q, halted_d;

   // warm_q is low only on the first edge after reset: IF has nothing latched yet.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= S_RUN;
         pc_q          <= RST_PC;
         cnt_q         <= 2'd0;
         warm_q        <= 1'b0;
         stall_cnt_q   <= 16'd0;
         if_flush_q    <= 1'b0;
         fetch_valid_q <= 1'b0;
         halted_q      <= 1'b0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         cnt_q         <= cnt_d;
         warm_q        <= 1'b1;
         stall_cnt_q   <= stall_cnt_d;
         if_flush_q    <= if_flush_d;
         fetch_valid_q <= fetch_valid_d;
         halted_q      <= halted_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      cnt_d     = cnt_q;
      stall_hit = 1'b0;
      if (state_q != S_HALT) begin
         if (bus.branch_taken) begin
            pc_d    = bus.branch_target;
            cnt_d   = FLUSH_LOAD;
            state_d = S_FLUSH;
         end else if (bus.jump) begin
            pc_d    = bus.jump_target;
            cnt_d   = FLUSH_LOAD;
            state_d = S_FLUSH;
         end else if (bus.halt_req) begin
            cnt_d   = 2'd0;
            state_d = S_HALT;
         end else if (bus.stall) begin
            // A stall inside FLUSH freezes the flush countdown along with the PC.
            stall_hit = 1'b1;
            if (state_q != S_FLUSH) state_d = S_STALL;
         end else if (state_q == S_FLUSH) begin
            pc_d  = pc_q + STEP;
            cnt_d = cnt_q - 2'd1;
            if (cnt_q == 2'd1) state_d = S_RUN;
         end else begin
            state_d = S_RUN;
            if (warm_q) pc_d = pc_q + STEP;
         end
      end
   end

   always_comb begin
      if_flush_d    = (state_d == S_FLUSH);
      fetch_valid_d = warm_q && (state_d == S_RUN || state_d == S_STALL);
      halted_d      = (state_d == S_HALT);
      stall_cnt_d   = stall_cnt_q;
      if (stall_hit && stall_cnt_q != 16'hFFFF) stall_cnt_d = stall_cnt_q + 16'd1;
   end

   assign bus.pc_out       = pc_q;
   assign bus.if_flush     = if_flush_q;
   assign bus.fetch_valid  = fetch_valid_q;
   assign bus.halted       = halted_q;
   assign bus.stall_cycles = stall_cnt_q;
   assign state_dbg        = state_q;
endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: two instances (FLUSH_CYCLES 1 and 3) share stimulus and
// are compared against a cycle-level behavioural model plus directed scenarios.
module tb_fetch_ctrl;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       drv_stall = 1'b0, drv_br = 1'b0, drv_jmp = 1'b0, drv_halt = 1'b0;
   logic [7:0] drv_bt = 8'd0, drv_jt = 8'd0;
   logic [1:0] st1, st3;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   fetch_if #(.PC_W(8)) bus1 ();
   fetch_if #(.PC_W(8)) bus3 ();

   assign bus1.stall = drv_stall;  assign bus3.stall = drv_stall;
   assign bus1.branch_taken = drv_br;  assign bus3.branch_taken = drv_br;
   assign bus1.branch_target = drv_bt; assign bus3.branch_target = drv_bt;
   assign bus1.jump = drv_jmp;  assign bus3.jump = drv_jmp;
   assign bus1.jump_target = drv_jt;  assign bus3.jump_target = drv_jt;
   assign bus1.halt_req = drv_halt;  assign bus3.halt_req = drv_halt;

   fetch_ctrl #(.PC_W(8), .RESET_PC(0), .PC_STEP(1), .FLUSH_CYCLES(1)) dut1 (
      .clk(clk), .rst(rst), .bus(bus1), .state_dbg(st1));
   fetch_ctrl #(.PC_W(8), .RESET_PC(0), .PC_STEP(1), .FLUSH_CYCLES(3)) dut3 (
      .clk(clk), .rst(rst), .bus(bus3), .state_dbg(st3));

   // Behavioural model, index 0 -> FLUSH_CYCLES 1, index 1 -> FLUSH_CYCLES 3.
   int m_pc[2], m_left[2], m_age[2], m_stalls[2];
   bit m_halt[2];
   int fl[2] = '{1, 3};
   logic [7:0] exp_q[$];

   task automatic model_step();
      for (int k = 0; k < 2; k++) begin
         if (rst) begin
            m_pc[k] = 0; m_left[k] = 0; m_age[k] = 0; m_stalls[k] = 0; m_halt[k] = 0;
         end else begin
            bit first = (m_age[k] == 0);
            if (m_age[k] < 2) m_age[k]++;
            if (m_halt[k]) begin
            end else if (drv_br) begin
               m_pc[k] = drv_bt; m_left[k] = fl[k];
            end else if (drv_jmp) begin
               m_pc[k] = drv_jt; m_left[k] = fl[k];
            end else if (drv_halt) begin
               m_halt[k] = 1; m_left[k] = 0;
            end else if (drv_stall) begin
               if (m_stalls[k] < 65535) m_stalls[k]++;
            end else if (m_left[k] > 0) begin
               m_pc[k] = (m_pc[k] + 1) % 256; m_left[k]--;
            end else if (!first) begin
               m_pc[k] = (m_pc[k] + 1) % 256;
            end
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic idle();
      drv_stall = 0; drv_br = 0; drv_jmp = 0; drv_halt = 0;
   endtask

   task automatic advance_to(input logic [7:0] target);
      int n = 0;
      while (bus1.pc_out !== target && n < 300) begin tick(); n++; end
      n_checks++;
      if (bus1.pc_out !== target) $display("FAIL advance_to got %0h want %0h", bus1.pc_out, target);
      else n_pass++;
   endtask

   task automatic test_reset();
      logic [7:0] e;
      logic       fv_exp[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      idle(); rst = 1;
      tick();
      exp_q = '{8'd0, 8'd0, 8'd1, 8'd2, 8'd3};
      n_checks++;
      if (bus1.if_flush !== 0 || bus1.halted !== 0 || bus1.stall_cycles !== 0)
         $display("FAIL reset_vals flush %b halted %b sc %0d want 0 0 0", bus1.if_flush, bus1.halted, bus1.stall_cycles);
      else n_pass++;
      rst = 0;
      for (int i = 0; i < 5; i++) begin
         if (i > 0) tick();
         e = exp_q.pop_front();
         n_checks++;
         if (bus1.pc_out !== e) $display("FAIL reset_pc[%0d] got %0d want %0d", i, bus1.pc_out, e);
         else n_pass++;
         n_checks++;
         if (bus1.fetch_valid !== fv_exp[i]) $display("FAIL reset_fv[%0d] got %b want %b", i, bus1.fetch_valid, fv_exp[i]);
         else n_pass++;
      end
   endtask

   task automatic test_stall();
      advance_to(8'd5);
      drv_stall = 1;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_checks++;
         if (bus1.pc_out !== 8'd5) $display("FAIL stall_hold[%0d] got %0d want 5", i, bus1.pc_out);
         else n_pass++;
      end
      drv_stall = 0;
      tick();
      n_checks++;
      if (bus1.pc_out !== 8'd6) $display("FAIL stall_release got %0d want 6", bus1.pc_out);
      else n_pass++;
      n_checks++;
      if (bus1.stall_cycles !== 16'd3) $display("FAIL stall_count got %0d want 3", bus1.stall_cycles);
      else n_pass++;
   endtask

   task automatic test_branch();
      advance_to(8'd9);
      drv_br = 1; drv_bt = 8'h40;
      tick();
      idle();
      n_checks++;
      if (bus1.pc_out !== 8'h40 || bus1.if_flush !== 1 || bus1.fetch_valid !== 0)
         $display("FAIL branch_redirect pc %0h flush %b fv %b want 40 1 0", bus1.pc_out, bus1.if_flush, bus1.fetch_valid);
      else n_pass++;
      tick();
      n_checks++;
      if (bus1.pc_out !== 8'h41 || bus1.if_flush !== 0 || bus1.fetch_valid !== 1)
         $display("FAIL branch_after pc %0h flush %b fv %b want 41 0 1", bus1.pc_out, bus1.if_flush, bus1.fetch_valid);
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      drv_br = 1; drv_bt = 8'h10; drv_jmp = 1; drv_jt = 8'h20; drv_stall = 1;
      tick();
      idle();
      n_checks++;
      if (bus1.pc_out !== 8'h10 || bus1.stall_cycles !== 16'd3)
         $display("FAIL branch_over_jump pc %0h sc %0d want 10 3", bus1.pc_out, bus1.stall_cycles);
      else n_pass++;
      tick();
      drv_jmp = 1; drv_jt = 8'h20; drv_halt = 1;
      tick();
      idle();
      n_checks++;
      if (bus1.pc_out !== 8'h20 || bus1.halted !== 0 || bus1.if_flush !== 1)
         $display("FAIL jump_over_halt pc %0h halted %b flush %b want 20 0 1", bus1.pc_out, bus1.halted, bus1.if_flush);
      else n_pass++;
      tick();
   endtask

   task automatic test_wrap_halt();
      drv_jmp = 1; drv_jt = 8'hFE;
      tick();
      idle();
      tick();
      n_checks++;
      if (bus1.pc_out !== 8'hFF) $display("FAIL pre_wrap got %0h want ff", bus1.pc_out);
      else n_pass++;
      tick();
      n_checks++;
      if (bus1.pc_out !== 8'h00) $display("FAIL wrap got %0h want 00", bus1.pc_out);
      else n_pass++;
      tick();
      drv_halt = 1;
      tick();
      idle();
      n_checks++;
      if (bus1.halted !== 1 || bus1.fetch_valid !== 0 || bus1.pc_out !== 8'h01)
         $display("FAIL halt_enter halted %b fv %b pc %0h want 1 0 01", bus1.halted, bus1.fetch_valid, bus1.pc_out);
      else n_pass++;
      drv_br = 1; drv_bt = 8'h77;
      tick(); tick();
      idle();
      n_checks++;
      if (bus1.pc_out !== 8'h01 || bus1.halted !== 1 || bus1.if_flush !== 0)
         $display("FAIL halt_ignores_branch pc %0h halted %b flush %b want 01 1 0", bus1.pc_out, bus1.halted, bus1.if_flush);
      else n_pass++;
      rst = 1;
      tick();
      rst = 0;
      n_checks++;
      if (bus1.pc_out !== 8'h00 || bus1.halted !== 0) $display("FAIL halt_reset pc %0h halted %b want 00 0", bus1.pc_out, bus1.halted);
      else n_pass++;
   endtask

   task automatic test_saturation();
      drv_stall = 1;
      for (int i = 0; i < 65534; i++) tick();
      n_checks++;
      if (bus1.stall_cycles !== 16'hFFFE) $display("FAIL sat_edge got %0h want fffe", bus1.stall_cycles);
      else n_pass++;
      for (int i = 65534; i < 70000; i++) tick();
      drv_stall = 0;
      n_checks++;
      if (bus1.stall_cycles !== 16'hFFFF || bus3.stall_cycles !== 16'hFFFF)
         $display("FAIL saturate got %0h/%0h want ffff", bus1.stall_cycles, bus3.stall_cycles);
      else n_pass++;
   endtask

   task automatic test_mid_flush_reset();
      idle();
      drv_jmp = 1; drv_jt = 8'h30;
      tick();
      idle();
      n_checks++;
      if (bus3.if_flush !== 1 || bus3.pc_out !== 8'h30) $display("FAIL flush3_first flush %b pc %0h want 1 30", bus3.if_flush, bus3.pc_out);
      else n_pass++;
      tick();
      n_checks++;
      if (bus3.if_flush !== 1 || bus3.pc_out !== 8'h31) $display("FAIL flush3_second flush %b pc %0h want 1 31", bus3.if_flush, bus3.pc_out);
      else n_pass++;
      rst = 1;
      tick();
      rst = 0;
      n_checks++;
      if (bus3.if_flush !== 0 || bus3.pc_out !== 8'h00 || bus3.stall_cycles !== 16'd0)
         $display("FAIL mid_flush_reset flush %b pc %0h sc %0d want 0 00 0", bus3.if_flush, bus3.pc_out, bus3.stall_cycles);
      else n_pass++;
      tick(); tick();
      n_checks++;
      if (bus3.if_flush !== 0 || bus3.pc_out !== 8'h01) $display("FAIL flush_cleared flush %b pc %0h want 0 01", bus3.if_flush, bus3.pc_out);
      else n_pass++;
   endtask

   task automatic test_random();
      logic [7:0]  gpc[2];
      logic        gfl[2], gfv[2], ghl[2];
      logic [15:0] gsc[2];
      int          bad = 0;
      for (int c = 0; c < 3000; c++) begin
         rst       = ($urandom_range(99, 0) < 1);
         drv_halt  = ($urandom_range(99, 0) < 1);
         drv_br    = ($urandom_range(99, 0) < 8);
         drv_jmp   = ($urandom_range(99, 0) < 8);
         drv_stall = ($urandom_range(99, 0) < 20);
         drv_bt    = 8'($urandom_range(255, 0));
         drv_jt    = 8'($urandom_range(255, 0));
         tick();
         gpc[0] = bus1.pc_out; gfl[0] = bus1.if_flush; gfv[0] = bus1.fetch_valid;
         ghl[0] = bus1.halted; gsc[0] = bus1.stall_cycles;
         gpc[1] = bus3.pc_out; gfl[1] = bus3.if_flush; gfv[1] = bus3.fetch_valid;
         ghl[1] = bus3.halted; gsc[1] = bus3.stall_cycles;
         for (int k = 0; k < 2; k++) begin
            logic [7:0]  e_pc = 8'(m_pc[k]);
            logic        e_fl = (m_left[k] > 0) && !m_halt[k];
            logic        e_fv = (m_age[k] >= 2) && !m_halt[k] && (m_left[k] == 0);
            logic [15:0] e_sc = 16'(m_stalls[k]);
            n_checks++;
            if (gpc[k] !== e_pc || gfl[k] !== e_fl || gfv[k] !== e_fv || ghl[k] !== m_halt[k] || gsc[k] !== e_sc) begin
               bad++;
               if (bad <= 10)
                  $display("FAIL random[%0d] dut%0d pc %0h fl %b fv %b hl %b sc %0d want %0h %b %b %b %0d",
                           c, k, gpc[k], gfl[k], gfv[k], ghl[k], gsc[k], e_pc, e_fl, e_fv, m_halt[k], e_sc);
            end else n_pass++;
         end
      end
      rst = 0;
      idle();
   endtask

   initial begin
      test_reset();
      test_stall();
      test_branch();
      test_back_to_back();
      test_wrap_halt();
      test_saturation();
      test_mid_flush_reset();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
